// File: rtl/fp_pipe_pkg.sv
// Shared int/FP pipeline definitions.
// Register geometry and operand source/destination select encodings.
package fp_pipe_pkg;

    localparam int REG_W = 5;
    localparam int NREGS = 32;

    typedef logic [REG_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_INT  = 2'b01,
        SRC_FP   = 2'b10
    } src_sel_e;

    typedef enum logic [1:0] {
        RD_NONE = 2'b00,
        RD_INT  = 2'b01,
        RD_FP   = 2'b10,
        RD_BOTH = 2'b11
    } rd_sel_e;

    function automatic src_sel_e src_sel(input logic used, input logic fp);
        if (!used) begin
            return SRC_NONE;
        end
        return fp ? SRC_FP : SRC_INT;
    endfunction

    function automatic rd_sel_e rd_sel(input logic int_en, input logic fp_en);
        return rd_sel_e'({fp_en, int_en});
    endfunction

endpackage

// File: rtl/fp_sb_regfile_bits.sv
// Pending-write bit vector for one register file.
// A same-cycle write-back hides the bit from the read checks.
module fp_sb_regfile_bits
    import fp_pipe_pkg::*;
#(
    parameter bit X0_ZERO = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  reg_addr_t             set_addr,
    input  logic                  clr_en,
    input  reg_addr_t             clr_addr,
    input  logic [2:0]            chk_en,
    input  logic [2:0][REG_W-1:0] chk_addr,
    output logic [2:0]            chk_hit,
    output logic [NREGS-1:0]      live
);

    localparam logic [NREGS-1:0] ONE = {{(NREGS-1){1'b0}}, 1'b1};

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    // Decode set/clear masks; a hard-wired zero register is never marked
    always_comb begin
        set_mask = set_en ? (ONE << set_addr) : '0;
        clr_mask = clr_en ? (ONE << clr_addr) : '0;
        if (X0_ZERO) begin
            set_mask[0] = 1'b0;
        end
    end

    assign live = pend_q & ~clr_mask;

    // Read checks see pending bits minus this cycle's write-back
    always_comb begin
        chk_hit = '0;
        for (int i = 0; i < 3; i++) begin
            chk_hit[i] = chk_en[i] & live[chk_addr[i]];
        end
    end

    // Next pending state: clear first, then set, so a new issue wins
    always_comb begin
        pend_d = (pend_q & ~clr_mask) | set_mask;
        if (rst) begin
            pend_d = '0;
        end
    end

    // Pending-bit register
    always_ff @(posedge clk) begin
        pend_q <= pend_d;
    end

endmodule

// File: rtl/fp_hazard_scoreboard.sv
// Issue controller for the int/FP pipeline: RAW/WAW/structural hazards,
// multi-cycle FP unit sequencing, stall counter and stuck-pipeline flag.
module fp_hazard_scoreboard
    import fp_pipe_pkg::*;
#(
    parameter int MULTI_LAT = 8,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rs3,
    input  logic             id_rs1_fp,
    input  logic             id_rs2_fp,
    input  logic             id_rs3_used,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd_addr,
    input  logic             id_wb_fp_en,
    input  logic             id_wb_int_en,
    input  logic             id_multi,
    input  logic             wb_fp_we,
    input  logic             wb_int_we,
    input  logic [4:0]       wb_rd_addr,
    output logic             stall,
    output logic             id_ex_bubble,
    output logic             issue,
    output logic             multi_busy,
    output logic [CNT_W-1:0] stall_count,
    output logic             hazard_timeout
);

    localparam int MW = $clog2(MULTI_LAT + 1);
    localparam logic [MW-1:0] LAT = MW'(MULTI_LAT);
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    src_sel_e s1;
    src_sel_e s2;
    src_sel_e s3;
    rd_sel_e  rds;

    logic [2:0]            int_chk_en;
    logic [2:0]            fp_chk_en;
    logic [2:0][REG_W-1:0] chk_addr;
    logic [2:0]            int_hit;
    logic [2:0]            fp_hit;
    logic [NREGS-1:0]      int_live;
    logic [NREGS-1:0]      fp_live;
    logic                  rd_int;
    logic                  rd_fp;
    logic                  raw;
    logic                  waw;
    logic                  strct;

    logic [MW-1:0]    cnt_q;
    logic [MW-1:0]    cnt_d;
    logic [CNT_W-1:0] scnt_q;
    logic [CNT_W-1:0] scnt_d;
    logic [7:0]       run_q;
    logic [7:0]       run_d;
    logic             tmo_q;
    logic             tmo_d;

    assign s1  = src_sel(id_rs1_used, id_rs1_fp);
    assign s2  = src_sel(id_rs2_used, id_rs2_fp);
    assign s3  = src_sel(id_rs3_used, 1'b1);
    assign rds = rd_sel(id_wb_int_en, id_wb_fp_en);

    assign rd_int = (rds == RD_INT) || (rds == RD_BOTH);
    assign rd_fp  = (rds == RD_FP) || (rds == RD_BOTH);

    assign int_chk_en = {1'b0, s2 == SRC_INT, s1 == SRC_INT};
    assign fp_chk_en  = {s3 == SRC_FP, s2 == SRC_FP, s1 == SRC_FP};
    assign chk_addr   = {id_rs3, id_rs2, id_rs1};

    fp_sb_regfile_bits #(
        .X0_ZERO (1'b1)
    ) u_int_bits (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue & rd_int),
        .set_addr (id_rd_addr),
        .clr_en   (wb_int_we),
        .clr_addr (wb_rd_addr),
        .chk_en   (int_chk_en),
        .chk_addr (chk_addr),
        .chk_hit  (int_hit),
        .live     (int_live)
    );

    fp_sb_regfile_bits #(
        .X0_ZERO (1'b0)
    ) u_fp_bits (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue & rd_fp),
        .set_addr (id_rd_addr),
        .clr_en   (wb_fp_we),
        .clr_addr (wb_rd_addr),
        .chk_en   (fp_chk_en),
        .chk_addr (chk_addr),
        .chk_hit  (fp_hit),
        .live     (fp_live)
    );

    // Hazard detection; int x0 never appears in int_live so it cannot hazard
    always_comb begin
        raw   = (|int_hit) | (|fp_hit);
        waw   = (rd_int & int_live[id_rd_addr]) | (rd_fp & fp_live[id_rd_addr]);
        strct = id_multi & multi_busy;
        stall = id_valid & (raw | waw | strct);
        issue = id_valid & ~stall;
    end

    assign id_ex_bubble   = stall;
    assign multi_busy     = (cnt_q != '0);
    assign stall_count    = scnt_q;
    assign hazard_timeout = tmo_q;

    // Multi-unit countdown, saturating stall counters and sticky timeout
    always_comb begin
        cnt_d  = cnt_q;
        scnt_d = scnt_q;
        run_d  = '0;
        tmo_d  = tmo_q;
        if (issue && id_multi) begin
            cnt_d = LAT;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - MW'(1);
        end
        if (stall) begin
            if (scnt_q != '1) begin
                scnt_d = scnt_q + CNT_W'(1);
            end
            run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
        end
        if (run_d >= TO_LIM) begin
            tmo_d = 1'b1;
        end
        if (rst) begin
            cnt_d  = '0;
            scnt_d = '0;
            run_d  = '0;
            tmo_d  = 1'b0;
        end
    end

    // Counter and flag registers
    always_ff @(posedge clk) begin
        cnt_q  <= cnt_d;
        scnt_q <= scnt_d;
        run_q  <= run_d;
        tmo_q  <= tmo_d;
    end

endmodule

// File: tb/tb_fp_hazard_scoreboard.sv
// Randomised + directed bench for fp_hazard_scoreboard.
// Expected responses are queued by the driver and checked by a monitor.
module tb_fp_hazard_scoreboard;

    localparam int LAT = 8;
    localparam int TO  = 255;
    localparam int SAT = 65535;

    typedef struct {
        bit v;
        int rs1, rs2, rs3;
        bit f1, f2, u1, u2, u3;
        int rd;
        bit wfp, wint, multi;
        bit wbfp, wbint;
        int wbrd;
        bit rst;
    } stim_t;

    typedef struct {
        int cyc;
        bit stall, issue, busy, tmo;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic id_valid;
    logic [4:0] id_rs1, id_rs2, id_rs3, id_rd_addr, wb_rd_addr;
    logic id_rs1_fp, id_rs2_fp, id_rs3_used, id_rs1_used, id_rs2_used;
    logic id_wb_fp_en, id_wb_int_en, id_multi, wb_fp_we, wb_int_we;
    logic stall, id_ex_bubble, issue, multi_busy, hazard_timeout;
    logic [15:0] stall_count;

    fp_hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
        .id_rs1_fp(id_rs1_fp), .id_rs2_fp(id_rs2_fp),
        .id_rs3_used(id_rs3_used), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .id_rd_addr(id_rd_addr),
        .id_wb_fp_en(id_wb_fp_en), .id_wb_int_en(id_wb_int_en),
        .id_multi(id_multi), .wb_fp_we(wb_fp_we), .wb_int_we(wb_int_we),
        .wb_rd_addr(wb_rd_addr), .stall(stall), .id_ex_bubble(id_ex_bubble),
        .issue(issue), .multi_busy(multi_busy), .stall_count(stall_count),
        .hazard_timeout(hazard_timeout)
    );

    always #5 clk = ~clk;

    // Reference model: sets of pending registers, time of last multi issue,
    // running totals of stall cycles.
    bit pend_int[32];
    bit pend_fp[32];
    longint cyc = 0;
    longint last_multi = -1000;
    int total = 0;
    int run = 0;
    bit tmo = 0;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    bit last_issue;

    function automatic bit live_int(stim_t s, int a);
        if (a == 0) return 1'b0;
        return pend_int[a] && !(s.wbint && s.wbrd == a);
    endfunction

    function automatic bit live_fp(stim_t s, int a);
        return pend_fp[a] && !(s.wbfp && s.wbrd == a);
    endfunction

    function automatic bit busy_now();
        return (cyc > last_multi) && (cyc - last_multi <= LAT);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            pend_int[i] = 0;
            pend_fp[i] = 0;
        end
        last_multi = -1000;
        total = 0;
        run = 0;
        tmo = 0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.v = ($urandom_range(0, 9) < 8);
        s.rs1 = $urandom_range(0, 3);
        s.rs2 = $urandom_range(0, 3);
        s.rs3 = $urandom_range(0, 3);
        s.f1 = $urandom_range(0, 1);
        s.f2 = $urandom_range(0, 1);
        s.u1 = $urandom_range(0, 1);
        s.u2 = $urandom_range(0, 1);
        s.u3 = ($urandom_range(0, 3) == 0);
        s.rd = $urandom_range(0, 3);
        s.multi = ($urandom_range(0, 4) == 0);
        s.wfp = s.multi | ($urandom_range(0, 1) == 1);
        s.wint = !s.wfp && ($urandom_range(0, 1) == 1);
        s.wbfp = ($urandom_range(0, 2) == 0);
        s.wbint = ($urandom_range(0, 2) == 0);
        s.wbrd = $urandom_range(0, 3);
        s.rst = ($urandom_range(0, 299) == 0);
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit raw, waw, st;
        @(posedge clk);
        #1;
        rst = s.rst;
        id_valid = s.v;
        id_rs1 = 5'(s.rs1);
        id_rs2 = 5'(s.rs2);
        id_rs3 = 5'(s.rs3);
        id_rs1_fp = s.f1;
        id_rs2_fp = s.f2;
        id_rs1_used = s.u1;
        id_rs2_used = s.u2;
        id_rs3_used = s.u3;
        id_rd_addr = 5'(s.rd);
        id_wb_fp_en = s.wfp;
        id_wb_int_en = s.wint;
        id_multi = s.multi;
        wb_fp_we = s.wbfp;
        wb_int_we = s.wbint;
        wb_rd_addr = 5'(s.wbrd);

        raw = (s.u1 && (s.f1 ? live_fp(s, s.rs1) : live_int(s, s.rs1)))
            || (s.u2 && (s.f2 ? live_fp(s, s.rs2) : live_int(s, s.rs2)))
            || (s.u3 && live_fp(s, s.rs3));
        waw = (s.wint && live_int(s, s.rd)) || (s.wfp && live_fp(s, s.rd));
        st = s.multi && busy_now();
        e.cyc = int'(cyc);
        e.stall = s.v && (raw || waw || st);
        e.issue = s.v && !e.stall;
        e.busy = busy_now();
        e.cnt = (total > SAT) ? SAT : total;
        e.tmo = tmo;
        q.push_back(e);
        last_issue = e.issue;

        if (s.rst) begin
            model_reset();
        end else begin
            if (s.wbint && s.wbrd != 0) pend_int[s.wbrd] = 0;
            if (s.wbfp) pend_fp[s.wbrd] = 0;
            if (e.issue && s.wint && s.rd != 0) pend_int[s.rd] = 1;
            if (e.issue && s.wfp) pend_fp[s.rd] = 1;
            if (e.issue && s.multi) last_multi = cyc;
            if (e.stall) begin
                total++;
                run++;
            end else begin
                run = 0;
            end
            if (run >= TO) tmo = 1;
        end
        cyc++;
    endtask

    task automatic check(input string name, input int c, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, got, exp);
        end
    endtask

    // Monitor: compare each queued expectation against the DUT away from the edge
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("stall", e.cyc, int'(stall), int'(e.stall));
            check("bubble", e.cyc, int'(id_ex_bubble), int'(e.stall));
            check("issue", e.cyc, int'(issue), int'(e.issue));
            check("multi_busy", e.cyc, int'(multi_busy), int'(e.busy));
            check("stall_count", e.cyc, int'(stall_count), e.cnt);
            check("hazard_timeout", e.cyc, int'(hazard_timeout), int'(e.tmo));
        end
    end

    initial begin
        stim_t s;
        stim_t r;
        rst = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs3 = 0;
        id_rs1_fp = 0; id_rs2_fp = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rs3_used = 0; id_rd_addr = 0; id_wb_fp_en = 0; id_wb_int_en = 0;
        id_multi = 0; wb_fp_we = 0; wb_int_we = 0; wb_rd_addr = 0;
        repeat (2) @(posedge clk);
        model_reset();
        r = idle();
        r.rst = 1;
        step(r);
        step(idle());

        // fadd f3, then fmul f4,f3,f1 held until WB writes f3
        s = idle(); s.v = 1; s.rd = 3; s.wfp = 1;
        step(s);
        s = idle(); s.v = 1; s.u1 = 1; s.f1 = 1; s.rs1 = 3;
        s.u2 = 1; s.f2 = 1; s.rs2 = 1; s.rd = 4; s.wfp = 1;
        repeat (3) step(s);
        s.wbfp = 1; s.wbrd = 3;
        step(s);
        step(idle());

        // add x0, then a use of x0
        s = idle(); s.v = 1; s.rd = 0; s.wint = 1;
        step(s);
        s = idle(); s.v = 1; s.u1 = 1; s.rs1 = 0; s.u2 = 1; s.rs2 = 0;
        step(s);

        // fdiv, gap, second fdiv held on the busy unit
        s = idle(); s.v = 1; s.multi = 1; s.wfp = 1; s.rd = 8;
        step(s);
        step(idle());
        s.rd = 9;
        for (int i = 0; i < 20; i++) begin
            step(s);
            if (last_issue) break;
        end
        repeat (10) step(idle());

        // WB clears f5 while ID issues a write to f5; next read of f5 stalls
        s = idle(); s.v = 1; s.rd = 5; s.wfp = 1;
        step(s);
        s.wbfp = 1; s.wbrd = 5;
        step(s);
        s = idle(); s.v = 1; s.u1 = 1; s.f1 = 1; s.rs1 = 5;
        step(s);
        s.wbfp = 1; s.wbrd = 5;
        step(s);

        // Stuck RAW for the timeout window, then reset discards everything
        step(r);
        s = idle(); s.v = 1; s.rd = 3; s.wfp = 1;
        step(s);
        s = idle(); s.v = 1; s.u1 = 1; s.f1 = 1; s.rs1 = 3;
        repeat (TO + 2) step(s);
        step(r);
        step(s);
        step(idle());

        // Long stall to drive the performance counter into saturation
        s = idle(); s.v = 1; s.rd = 6; s.wfp = 1;
        step(s);
        s = idle(); s.v = 1; s.u3 = 1; s.rs3 = 6;
        repeat (70000) step(s);
        step(idle());
        step(r);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step(rnd());
        end
        step(idle());

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
